// File: rtl/bridge_pkg.sv
// bridge_pkg: shared FSM state and access-size encodings for the SRAM-like bus bridges
package bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        HOLD = 2'd3
    } bridge_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/data_sram_bridge.sv
// data_sram_bridge: MEM-stage to SRAM-like data bus bridge, one bus transaction per access
// Ports: clk/rst (async active-low); mem_* MEM-stage access in, mem_rdata/stallreq_from_mem out;
//        pipe_stall = other stall sources; data_* SRAM-like bus (req/addr_ok/data_ok handshake).
module data_sram_bridge
    import bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        mem_we,
    input  logic [3:0]  mem_sel,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_flush,
    input  logic        pipe_stall,
    output logic [31:0] mem_rdata,
    output logic        stallreq_from_mem,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [3:0]  data_wstrb,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata
);

    bridge_state_e state, state_nxt;
    logic          req_we;
    logic [1:0]    req_size;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_wstrb;
    logic [31:0]   hold_q;
    logic          take;
    logic          rdata_fire;

    assign take       = mem_en && !mem_flush;
    assign rdata_fire = (state == DATA) && data_data_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Flush is only honoured in IDLE and HOLD; an issued transaction always runs to data_ok.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = take ? ADDR : IDLE;
            ADDR:    state_nxt = data_addr_ok ? DATA : ADDR;
            DATA:    state_nxt = !data_data_ok ? DATA : (pipe_stall ? HOLD : IDLE);
            HOLD:    state_nxt = (!pipe_stall || mem_flush) ? IDLE : HOLD;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        data_req          = (state == ADDR);
        stallreq_from_mem = (state == IDLE) ? take :
                            (state == ADDR) ? 1'b1 :
                            (state == DATA) ? !data_data_ok : 1'b0;
        // Bypass the hold register on the completion cycle so the pipeline can advance immediately.
        mem_rdata         = rdata_fire ? data_rdata : hold_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_we    <= 1'b0;
            req_size  <= SIZE_BYTE;
            req_addr  <= '0;
            req_wdata <= '0;
            req_wstrb <= '0;
            hold_q    <= '0;
        end else begin
            if (state == IDLE && take) begin
                req_we    <= mem_we;
                req_size  <= mem_size;
                req_addr  <= mem_addr;
                req_wdata <= mem_wdata;
                req_wstrb <= mem_we ? mem_sel : 4'b0;
            end
            if (rdata_fire) hold_q <= data_rdata;
        end
    end

    assign data_wr    = req_we;
    assign data_size  = req_size;
    assign data_addr  = req_addr;
    assign data_wdata = req_wdata;
    assign data_wstrb = req_wstrb;

endmodule

// File: doc/data_sram_bridge.md
# data_sram_bridge

Data-side bus bridge between the datapath MEM stage and the SRAM-like data bus (req / addr_ok / data_ok). It accepts the single-cycle MEM-stage access (`mem_en`, `mem_we`, `sel`, address, `mem_wdata_last`, `mem_size`) and issues exactly one bus transaction per access. It raises `stallreq_from_mem` until the data phase completes. It holds returned read data stable while other stall sources keep the pipeline frozen.

## Interface
Parameters:
- none; widths fixed at 32-bit address/data, 4-bit strobe.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; asynchronous, active-low
- mem_en  in  1  MEM-stage access valid
- mem_we  in  1  access is a store
- mem_sel  in  4  byte lanes (from datapath `sel`)
- mem_size  in  2  0 = byte, 1 = half, 2 = word
- mem_addr  in  32  byte address (MEM-stage ALU result)
- mem_wdata  in  32  lane-aligned store data
- mem_flush  in  1  exception/ERET flush of MEM stage
- pipe_stall  in  1  stall from any source other than this block (e.g. `stallreq_from_if`)
- mem_rdata  out  32  load data to MEM stage
- stallreq_from_mem  out  1  freeze pipeline
- data_req  out  1  bus request
- data_wr  out  1  1 = write
- data_size  out  2  copy of mem_size
- data_addr  out  32  copy of mem_addr
- data_wstrb  out  4  mem_sel when write, else 4'b0
- data_wdata  out  32  store data
- data_addr_ok  in  1  address phase accepted
- data_data_ok  in  1  data phase done; data_rdata valid
- data_rdata  in  32  bus read data

## Operation
- FSM states: IDLE, ADDR, DATA, HOLD.
- IDLE:
  - If `mem_en && !mem_flush`, capture we/size/addr/wdata/wstrb into request registers; next state ADDR.
  - `stallreq_from_mem = mem_en && !mem_flush` (combinational).
- ADDR:
  - `data_req = 1`; all bus fields come from the request registers and are constant while req is high.
  - On `data_addr_ok`, go to DATA. `stallreq_from_mem = 1`.
- DATA:
  - `data_req = 0`; `stallreq_from_mem = !data_data_ok`.
  - On `data_data_ok`: capture data_rdata into the hold register. `mem_rdata = data_rdata` the same cycle.
  - Next state is IDLE if `!pipe_stall`, else HOLD.
- HOLD:
  - `stallreq_from_mem = 0`; `mem_rdata` comes from the hold register.
  - Leave to IDLE when `!pipe_stall || mem_flush`.
- Only one transaction is outstanding; `data_req` is never asserted in DATA or HOLD.
- `mem_flush` in ADDR or DATA is ignored. A bus transaction is never cancelled; it completes and its result is discarded by the pipeline.
- Stores follow the same path; `mem_rdata` is don't-care for stores but still follows the hold rule.
- No alignment checking; address exceptions are resolved upstream before `mem_en` is raised.

## Timing
- Reset (rst low, asynchronous):
  - state = IDLE.
  - data_req = 0, data_wr = 0, data_wstrb = 0, data_size = 0, data_addr = 0, data_wdata = 0.
  - Hold register = 0, so mem_rdata = 0.
- stallreq_from_mem is 0 in IDLE only when there is no valid access.
- Minimum access, with addr_ok and data_ok each seen on the first cycle they can be: access cycle (IDLE) + ADDR cycle + DATA cycle. data_ok lands in the DATA cycle, giving 2 stall cycles; the pipeline advances at the end of the DATA cycle.
- A reset mid-transaction abandons the bus state. The bus slave is reset from the same rst.
- Back-to-back accesses: after DATA or HOLD returns to IDLE, the next MEM instruction is sampled in the following cycle. There is no bubble beyond the IDLE capture cycle.

## Structure
- Shared package `bridge_pkg`:
  - FSM state enum {IDLE, ADDR, DATA, HOLD}.
  - Size constants SIZE_BYTE = 0, SIZE_HALF = 1, SIZE_WORD = 2.
  - The package is reused by the planned instruction-side bridge.
- Single flat module; no sub-module. The request register set and the read-hold register are local.

## Test plan
- Load word at 0x8000_0010, addr_ok 2 cycles after req, data_ok 3 cycles later with rdata 0xDEAD_BEEF -> req high only in ADDR; stallreq high until the data_ok cycle; mem_rdata = 0xDEAD_BEEF in that cycle.
- Store byte, sel 4'b0100, wdata 0x00AB_0000 -> data_wr = 1, data_wstrb = 4'b0100, data_size = 0; exactly one req/addr_ok pair.
- Load with pipe_stall held high for 4 cycles past data_ok (rdata 0x1234_5678), bus rdata changing afterwards -> HOLD state; mem_rdata stays 0x1234_5678; return to IDLE when pipe_stall drops.
- Back-to-back load then store, zero-latency slave -> two transactions; no duplicate req; 2 stall cycles each.
- rst asserted in DATA -> all outputs at reset values immediately, state IDLE; a fresh access after release works normally.
- mem_en with mem_flush in IDLE -> no req, stallreq = 0. mem_flush in ADDR -> transaction still completes, with req held until addr_ok.
